// File: rtl/iir1_sat_mac.sv
// Time-multiplexed first-order IIR stage y = a*x + b*y[n-1] with per-channel history,
// round-half-up after each product and saturation at every arithmetic step.
module iir1_sat_mac #(
   parameter int unsigned WIDTH = 22,
   parameter int unsigned FRAC  = 10,
   parameter int unsigned N_CH  = 2,
   parameter int unsigned CH_W  = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CH_W-1:0]         in_ch,
   input  logic signed [WIDTH-1:0] in_x,
   input  logic signed [WIDTH-1:0] coef_a,
   input  logic signed [WIDTH-1:0] coef_b,
   input  logic                    clear_hist,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CH_W-1:0]         out_ch,
   output logic signed [WIDTH-1:0] out_y,
   output logic                    sat_flag
);

   localparam int unsigned PW = 2 * WIDTH + 1;
   localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH - 1) {1'b1}}};
   localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH - 1) {1'b0}}};
   localparam logic signed [PW-1:0] RND = (FRAC == 0) ? '0 : (PW'(1) << (FRAC - 1));

   typedef enum logic [1:0] {StIdle, StMult, StSum, StOut} state_e;

   // Returns {clip, value}: round half-up, shift out FRAC bits, clip to WIDTH.
   function automatic logic [WIDTH:0] sat_prod(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      logic [PW-WIDTH:0]    hi;
      r  = (p + RND) >>> FRAC;
      hi = r[PW-1:WIDTH-1];
      if ((&hi) || !(|hi)) begin
         return {1'b0, r[WIDTH-1:0]};
      end
      return {1'b1, (r[PW-1] ? MINV : MAXV)};
   endfunction

   state_e state_q, state_d;

   logic signed [WIDTH-1:0] x_q, a_q, b_q, h_q;
   logic [CH_W-1:0]         ch_q;
   logic signed [WIDTH-1:0] pa_q, pb_q;
   logic                    clip_a_q, clip_b_q;
   logic signed [WIDTH-1:0] hist_q [N_CH];
   logic signed [WIDTH-1:0] out_y_q;
   logic [CH_W-1:0]         out_ch_q;
   logic                    out_valid_q, sat_q;

   logic                    ch_ok, accept;
   logic signed [PW-1:0]    prod_a, prod_b;
   logic [WIDTH:0]          res_a, res_b;
   logic [WIDTH:0]          sum;
   logic                    sum_clip;
   logic signed [WIDTH-1:0] sum_sat;

   assign in_ready  = (state_q == StIdle) && !reset;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_ch    = out_ch_q;
   assign sat_flag  = sat_q;

   always_comb begin
      ch_ok    = 32'(in_ch) < N_CH;
      accept   = in_valid && in_ready;
      prod_a   = PW'(a_q) * PW'(x_q);
      prod_b   = PW'(b_q) * PW'(h_q);
      res_a    = sat_prod(prod_a);
      res_b    = sat_prod(prod_b);
      // One guard bit is enough for the sum of two WIDTH-bit values.
      sum      = {pa_q[WIDTH-1], pa_q} + {pb_q[WIDTH-1], pb_q};
      sum_clip = sum[WIDTH] ^ sum[WIDTH-1];
      sum_sat  = sum_clip ? (sum[WIDTH] ? MINV : MAXV) : sum[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept && ch_ok) state_d = StMult;
         StMult: state_d = StSum;
         StSum:  state_d = StOut;
         StOut:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_ch_q    <= '0;
         sat_q       <= 1'b0;
         for (int i = 0; i < int'(N_CH); i++) hist_q[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StIdle: begin
               if (accept && ch_ok) begin
                  x_q  <= in_x;
                  a_q  <= coef_a;
                  b_q  <= coef_b;
                  ch_q <= in_ch;
                  h_q  <= hist_q[in_ch];
               end
            end
            StMult: begin
               clip_a_q <= res_a[WIDTH];
               pa_q     <= res_a[WIDTH-1:0];
               clip_b_q <= res_b[WIDTH];
               pb_q     <= res_b[WIDTH-1:0];
            end
            StSum: begin
               out_y_q      <= sum_sat;
               out_ch_q     <= ch_q;
               sat_q        <= clip_a_q | clip_b_q | sum_clip;
               hist_q[ch_q] <= sum_sat;
               out_valid_q  <= 1'b1;
            end
            StOut: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
         // Placed last so a clear on the history-write edge wins.
         if (clear_hist) begin
            for (int i = 0; i < int'(N_CH); i++) hist_q[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_iir1_sat_mac.sv
// Scoreboard bench for iir1_sat_mac: expected results queued at drive time, checked on output.
module tb_iir1_sat_mac;

   localparam int WIDTH = 22;
   localparam int FRAC  = 10;
   localparam int N_CH  = 3;
   localparam int CH_W  = 2;
   localparam longint MAXV = 2097151;
   localparam longint MINV = -2097152;

   logic                    clk, reset;
   logic                    in_valid, in_ready;
   logic [CH_W-1:0]         in_ch;
   logic signed [WIDTH-1:0] in_x, coef_a, coef_b;
   logic                    clear_hist;
   logic                    out_valid, out_ready;
   logic [CH_W-1:0]         out_ch;
   logic signed [WIDTH-1:0] out_y;
   logic                    sat_flag;

   iir1_sat_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .N_CH(N_CH), .CH_W(CH_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch     (in_ch),
      .in_x      (in_x),
      .coef_a    (coef_a),
      .coef_b    (coef_b),
      .clear_hist(clear_hist),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ch    (out_ch),
      .out_y     (out_y),
      .sat_flag  (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int     ch;
      longint y;
      bit     sat;
   } exp_t;

   exp_t   sb_q[$];
   longint hist_m[N_CH];
   int     n_cmp = 0;
   int     n_err = 0;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output monitor: pops one expectation per completed output handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_out", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("out_y", longint'(out_y), e.y);
               chk("out_ch", longint'(out_ch), longint'(e.ch));
               chk("sat_flag", longint'(sat_flag), longint'(e.sat));
            end
         end
      end
   end

   function automatic longint rnd_sat(input longint p, output bit c);
      longint r;
      r = (p + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
      c = 1'b0;
      if (r > MAXV) begin r = MAXV; c = 1'b1; end
      if (r < MINV) begin r = MINV; c = 1'b1; end
      return r;
   endfunction

   task automatic model(input int ch, input longint x, input longint a, input longint b,
                        output longint y, output bit sat);
      bit c1, c2, c3;
      longint pa, pb;
      pa = rnd_sat(a * x, c1);
      pb = rnd_sat(b * hist_m[ch], c2);
      y  = pa + pb;
      c3 = 1'b0;
      if (y > MAXV) begin y = MAXV; c3 = 1'b1; end
      if (y < MINV) begin y = MINV; c3 = 1'b1; end
      sat = c1 | c2 | c3;
   endtask

   task automatic send_raw(input int ch, input longint x, input longint a, input longint b);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("in_ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_ch    = CH_W'(ch);
      in_x     = WIDTH'(x);
      coef_a   = WIDTH'(a);
      coef_b   = WIDTH'(b);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send(input int ch, input longint x, input longint a, input longint b,
                       input longint exp_y, input bit exp_sat);
      exp_t e;
      e.ch  = ch;
      e.y   = exp_y;
      e.sat = exp_sat;
      sb_q.push_back(e);
      hist_m[ch] = exp_y;
      send_raw(ch, x, a, b);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb_q.size() != 0 || out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("drain_timeout", longint'(sb_q.size()), 0);
   endtask

   task automatic pulse_clear();
      wait_drain();
      @(negedge clk);
      clear_hist = 1'b1;
      @(posedge clk);
      #1 clear_hist = 1'b0;
      for (int i = 0; i < N_CH; i++) hist_m[i] = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit     seen;
      int     n;
      longint ey;
      bit     es;
      reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_x = '0; coef_a = '0; coef_b = '0;
      clear_hist = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) hist_m[i] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_out_y", longint'(out_y), 0);
      chk("rst_out_ch", longint'(out_ch), 0);
      chk("rst_sat", longint'(sat_flag), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", longint'(in_ready), 1);

      // Unity gain and latency
      send(0, 1000, 1024, 0, 1000, 0);
      @(negedge clk); chk("lat_k0", longint'(out_valid), 0);
      @(negedge clk); chk("lat_k1", longint'(out_valid), 0);
      @(negedge clk); chk("lat_k2", longint'(out_valid), 1);

      pulse_clear();
      send(0, 2048, 512, 512, 1024, 0);
      send(0, 2048, 512, 512, 1536, 0);
      send(0, 2048, 512, 512, 1792, 0);
      send(0, 2048, 512, 512, 1920, 0);

      pulse_clear();
      send(0, 2000000, 2048, 0, 2097151, 1);
      send(0, -2000000, 2048, 0, -2097152, 1);

      pulse_clear();
      send(0, 1500000, 1024, 1024, 1500000, 0);
      send(0, 1500000, 1024, 1024, 2097151, 1);
      send(1, 512, 1, 0, 1, 0);
      send(1, -512, 1, 0, 0, 0);

      pulse_clear();
      send(0, 2048, 512, 512, 1024, 0);
      send(1, -2048, 512, 512, -1024, 0);
      send(0, 2048, 512, 512, 1536, 0);
      send(1, -2048, 512, 512, -1536, 0);

      pulse_clear();
      send(0, 2048, 512, 512, 1024, 0);

      // Out-of-range channel is consumed and dropped
      wait_drain();
      send_raw(3, 5000, 1024, 1024);
      @(negedge clk);
      chk("drop_in_ready", longint'(in_ready), 1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen |= out_valid;
      end
      chk("drop_no_out", longint'(seen), 0);
      send(0, 2048, 512, 512, 1536, 0);

      // Backpressure
      wait_drain();
      out_ready = 1'b0;
      send(1, 2048, 512, 512, 1024, 0);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("bp_valid_timeout", 0, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", longint'(out_valid), 1);
         chk("bp_y", longint'(out_y), 1024);
         chk("bp_ch", longint'(out_ch), 1);
         chk("bp_sat", longint'(sat_flag), 0);
         chk("bp_in_ready", longint'(in_ready), 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_idle_ready", longint'(in_ready), 1);
      chk("bp_idle_valid", longint'(out_valid), 0);

      // Clear coincident with the history write
      wait_drain();
      send(2, 2048, 512, 512, 1024, 0);
      @(posedge clk);
      #1 clear_hist = 1'b1;
      @(posedge clk);
      #1 clear_hist = 1'b0;
      for (int i = 0; i < N_CH; i++) hist_m[i] = 0;
      send(2, 2048, 512, 512, 1024, 0);
      send(1, 2048, 512, 512, 1024, 0);

      // Reset while a sample sits in MULT
      wait_drain();
      send_raw(0, 2048, 512, 512);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_out_valid", longint'(out_valid), 0);
      chk("mrst_in_ready", longint'(in_ready), 0);
      reset = 1'b0;
      for (int i = 0; i < N_CH; i++) hist_m[i] = 0;
      @(negedge clk);
      chk("mrst_ready_after", longint'(in_ready), 1);
      send(0, 2048, 512, 512, 1024, 0);
      send(1, -2048, 512, 512, -1024, 0);

      // Random traffic against the reference model
      for (int i = 0; i < 30; i++) begin
         int     ch;
         longint x, a, b;
         ch = int'($urandom_range(0, N_CH - 1));
         a  = longint'($urandom_range(0, 4095)) - 2048;
         b  = longint'($urandom_range(0, 2047)) - 1024;
         x  = (i % 3 == 0) ? longint'($urandom_range(0, 4194303)) - 2097152
                           : longint'($urandom_range(0, 65535)) - 32768;
         model(ch, x, a, b, ey, es);
         send(ch, x, a, b, ey, es);
      end

      wait_drain();
      chk("sb_empty", longint'(sb_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/iir1_sat_mac.md
Name: iir1_sat_mac

Overview:
- Time-multiplexed first-order recursive filter stage: y[n] = a·x[n] + b·y[n-1] per channel.
- Fixed-point signed, with rounding and saturation at every arithmetic step.
- One arithmetic datapath shared by N_CH channels; each channel keeps its own y history.
- Sits between the sample source and the DAC/output formatter in the recursive-filter chain. Generalises the combinational saturating adder with multiply, rounding, per-channel state and valid/ready handshakes.

Parameters:
- WIDTH, 22: sample/coefficient/result width, signed two's complement.
- FRAC, 10: fractional bits of coefficients (Q(WIDTH-FRAC).FRAC); 1.0 = 2**FRAC.
- N_CH, 2: number of channels (1..16).
- CH_W, 1: in_ch/out_ch width = max(1, clog2(N_CH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block can accept a sample.
- in_ch  in  CH_W  channel of offered sample.
- in_x  in  WIDTH  signed input sample.
- coef_a  in  WIDTH  signed feed-forward coefficient, sampled at accept.
- coef_b  in  WIDTH  signed feedback coefficient, sampled at accept.
- clear_hist  in  1  synchronous clear of all channel histories.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_ch  out  CH_W  channel of result.
- out_y  out  WIDTH  signed filtered result.
- sat_flag  out  1  at least one saturation occurred computing out_y.

Behaviour:
- One clock (clk). Reset is synchronous and active-high: on a clk edge with reset=1, the following apply, overriding all other activity including mid-operation:
  - state <= IDLE; all histories <= 0.
  - out_valid, out_y, out_ch, sat_flag <= 0.
  - in_ready = 0 while reset is high.
- Saturation limits: MAXV = 2**(WIDTH-1)-1, MINV = -2**(WIDTH-1). Results are clipped to these, never wrapped.
- FSM states: IDLE, MULT, SUM, OUT.
  - IDLE: in_ready=1. On an edge with in_valid=1 and in_ch<N_CH, capture x, ch, a, b and the history h=hist[ch]; go to MULT.
  - IDLE, in_ch>=N_CH: sample is consumed (handshake completes) and dropped; no output; stay IDLE.
  - MULT: pa = a·x and pb = b·h as full 2·WIDTH-bit signed products.
    - Round half-up: add 2**(FRAC-1), then arithmetic shift right by FRAC.
    - Saturate each to WIDTH. Register both and their clip bits; go to SUM.
  - SUM: s = pa + pb computed at WIDTH+1 bits, saturated to WIDTH.
    - Register out_y=s, out_ch=ch; sat_flag = OR of three clip bits.
    - Write hist[ch] <= s; out_valid <= 1; go to OUT.
  - OUT: out_valid=1. out_y, out_ch, sat_flag held stable until an edge with out_ready=1, then out_valid <= 0 and go to IDLE.
- in_ready=0 in MULT/SUM/OUT. No input buffering.
- Latency: accept at edge k → out_valid high after edge k+2. Best-case throughput is one sample per 4 cycles.
- clear_hist:
  - Zeroes all histories on that edge, in any state.
  - If coincident with the SUM-state history write, clear wins: the history is 0, and out_y still carries s.
  - A sample already captured in MULT keeps its captured h.
- FRAC=0 is legal: no rounding term is added.
- Coefficients are not retained between samples.

Test Plan:
- a=1024, b=0, ch0 x=1000 → out_y=1000, sat_flag=0, out_ch=0; out_valid high after edge k+2.
- a=512, b=512, ch0 x=2048 four times → out_y=1024, 1536, 1792, 1920, sat_flag=0 on each.
- Product clip: a=2048, b=0, x=2000000 → out_y=2097151, sat_flag=1. Same with x=-2000000 → out_y=-2097152, sat_flag=1.
- Sum clip and rounding:
  - a=1024, b=1024, ch0 x=1500000 twice → out_y=1500000 then 2097151 with sat_flag=1.
  - a=1, b=0, x=512 → out_y=1; x=-512 → out_y=0.
- Channel isolation and clear:
  - a=b=512, interleave ch0 x=2048 and ch1 x=-2048 → ch0 gives 1024, 1536; ch1 gives -1024, -1536.
  - Pulse clear_hist, next ch0 x=2048 → out_y=1024.
  - in_ch=3 with N_CH=2 → accepted, no out_valid, histories unchanged.
- Backpressure and reset:
  - out_ready=0 for 5 cycles in OUT → out_valid, out_y, out_ch, sat_flag constant, in_ready=0.
  - Raise out_ready → IDLE next edge.
  - reset during MULT → next cycle out_valid=0, histories 0, in_ready=1 after reset drops.
